// File: rtl/riscv_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : riscv_ctrl_pkg
// Purpose  : Shared encodings for the RV32I multi-cycle controller.
//            Macro ILLEGAL_TRAP_EN adds the HALT state.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_ctrl_pkg;

    localparam int STATE_BITS = 4;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b110;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_LINK     = 4'd12,
        S_LUI      = 4'd13
`ifdef ILLEGAL_TRAP_EN
        ,
        S_HALT     = 4'd14
`endif
    } state_e;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_LW, OP_JALR, OP_I: imm_sel = IMM_I;
            OP_SW:                imm_sel = IMM_S;
            OP_B:                 imm_sel = IMM_B;
            OP_LUI:               imm_sel = IMM_U;
            OP_JAL:               imm_sel = IMM_J;
            default:              imm_sel = IMM_I;
        endcase
    endfunction

    // SUB exists only for R-type; addi with imm[10]=1 must stay ADD.
    function automatic logic [2:0] alu_dec(input logic [2:0] f3, input logic f7_5,
                                           input logic is_r);
        case (f3)
            3'b000:  alu_dec = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
            3'b111:  alu_dec = ALU_AND;
            3'b110:  alu_dec = ALU_OR;
            3'b100:  alu_dec = ALU_XOR;
            3'b010:  alu_dec = ALU_SLT;
            default: alu_dec = ALU_ADD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond_unit.sv
//------------------------------------------------------------------------------
// Module   : branch_cond_unit
// Purpose  : Combinational branch-taken decision from func3 and ALU flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module branch_cond_unit
    import riscv_ctrl_pkg::*;
(
    input  logic [2:0] func3,
    input  logic       zero,
    input  logic       lt,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (func3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            default: taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multi_cycle_controller.sv
//------------------------------------------------------------------------------
// Module   : multi_cycle_controller
// Purpose  : Main control FSM of the RV32I multi-cycle core.
//            Macro ILLEGAL_TRAP_EN traps unknown opcodes into HALT.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multi_cycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [6:0]         opcode,
    input  logic [2:0]         func3,
    input  logic               func7_5,
    input  logic               zero,
    input  logic               lt,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         imm_src,
    output logic [2:0]         alu_ctrl,
    output logic               illegal,
    output logic [STATE_W-1:0] state_dbg
);

    state_e state_q;
    state_e state_d;
    logic   taken;
    logic   pc_write_fsm;
    logic   mem_write_fsm;
    logic   ir_write_fsm;
    logic   reg_write_fsm;

    branch_cond_unit u_branch_cond (
        .func3 (func3),
        .zero  (zero),
        .lt    (lt),
        .taken (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_write_fsm  = 1'b0;
        mem_write_fsm = 1'b0;
        ir_write_fsm  = 1'b0;
        reg_write_fsm = 1'b0;
        adr_src       = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_ctrl      = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_fsm = 1'b1;
                pc_write_fsm = 1'b1;
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALU;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_B:         state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src    = RES_MEM;
                reg_write_fsm = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_fsm = 1'b1;
                state_d       = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_ctrl  = alu_dec(func3, func7_5, 1'b1);
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = alu_dec(func3, func7_5, 1'b0);
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_fsm = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = SRCA_RS1;
                alu_ctrl     = ALU_SUB;
                pc_write_fsm = taken;
                state_d      = S_FETCH;
            end
            // JAL target was latched into ALUOut during DECODE; ALU now forms the link.
            S_JAL: begin
                alu_src_a    = SRCA_OLDPC;
                alu_src_b    = SRCB_FOUR;
                pc_write_fsm = 1'b1;
                state_d      = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a    = SRCA_RS1;
                alu_src_b    = SRCB_IMM;
                result_src   = RES_ALU;
                pc_write_fsm = 1'b1;
                state_d      = S_LINK;
            end
            S_LINK: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                state_d   = S_ALUWB;
            end
            S_LUI: begin
                alu_src_b     = SRCB_IMM;
                alu_ctrl      = ALU_PASSB;
                result_src    = RES_ALU;
                reg_write_fsm = 1'b1;
                state_d       = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_HALT: begin
                state_d = S_HALT;
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Strobes are suppressed for the whole reset window, not just after the edge.
    assign pc_write  = pc_write_fsm  & ~rst;
    assign mem_write = mem_write_fsm & ~rst;
    assign ir_write  = ir_write_fsm  & ~rst;
    assign reg_write = reg_write_fsm & ~rst;

    assign imm_src   = imm_sel(opcode);
    assign state_dbg = STATE_W'(state_q);

`ifdef ILLEGAL_TRAP_EN
    assign illegal = (state_q == S_HALT);
`else
    assign illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_multi_cycle_controller
// Purpose  : Self-checking bench for multi_cycle_controller against an
//            instruction-level model. Honors ILLEGAL_TRAP_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_cycle_controller;
    import riscv_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       func7_5;
    logic       zero;
    logic       lt;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src, alu_ctrl;
    logic [3:0] state_dbg;

    multi_cycle_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .func3      (func3),
        .func7_5    (func7_5),
        .zero       (zero),
        .lt         (lt),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .alu_ctrl   (alu_ctrl),
        .illegal    (illegal),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    // One cycle of expected behaviour; brn marks the cycle whose pc_write follows the branch rule.
    typedef struct packed {
        logic       pcw, adr, memw, irw, regw;
        logic [1:0] rs, a, b;
        logic [2:0] alu;
        logic       brn;
    } cyc_t;

    cyc_t seq [8];
    int   seq_len;
    cyc_t obs [8];

    function automatic cyc_t mk(input logic pcw, input logic adr, input logic memw,
                                input logic irw, input logic regw, input logic [1:0] rs,
                                input logic [1:0] a, input logic [1:0] b,
                                input logic [2:0] alu, input logic brn);
        cyc_t c;
        c.pcw = pcw; c.adr = adr; c.memw = memw; c.irw = irw; c.regw = regw;
        c.rs = rs; c.a = a; c.b = b; c.alu = alu; c.brn = brn;
        return c;
    endfunction

    function automatic logic [2:0] alu_of(input logic [2:0] f3, input logic f75, input logic is_r);
        case (f3)
            3'd0:    return (is_r && f75) ? 3'd1 : 3'd0;
            3'd7:    return 3'd2;
            3'd6:    return 3'd3;
            3'd4:    return 3'd4;
            3'd2:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [2:0] imm_of(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b1100111, 7'b0010011: return 3'd0;
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b0110111: return 3'd3;
            7'b1101111: return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

    function automatic void push(input cyc_t c);
        seq[seq_len] = c;
        seq_len++;
    endfunction

    // Instruction-level model: the per-cycle control pattern of one whole instruction.
    function automatic void build(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        cyc_t wb, ea;
        wb = mk(0, 0, 0, 0, 1, 2'd0, 2'd0, 2'd0, 3'd0, 0);
        ea = mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 3'd0, 0);
        seq_len = 0;
        push(mk(1, 0, 0, 1, 0, 2'd2, 2'd0, 2'd2, 3'd0, 0));
        push(mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd1, 3'd0, 0));
        case (op)
            7'b0000011: begin
                push(ea);
                push(mk(0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
                push(mk(0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 3'd0, 0));
            end
            7'b0100011: begin
                push(ea);
                push(mk(0, 1, 1, 0, 0, 2'd0, 2'd0, 2'd0, 3'd0, 0));
            end
            7'b0110011: begin
                push(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, alu_of(f3, f75, 1'b1), 0));
                push(wb);
            end
            7'b0010011: begin
                push(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, alu_of(f3, f75, 1'b0), 0));
                push(wb);
            end
            7'b1100011: push(mk(0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 3'd1, 1));
            7'b1101111: begin
                push(mk(1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 0));
                push(wb);
            end
            7'b1100111: begin
                push(mk(1, 0, 0, 0, 0, 2'd2, 2'd2, 2'd1, 3'd0, 0));
                push(mk(0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 3'd0, 0));
                push(wb);
            end
            7'b0110111: push(mk(0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd1, 3'd6, 0));
            default: ;
        endcase
    endfunction

    int          chk_mode = 0;   // 0 idle, 1 full model compare, 2 reset-strobe compare
    int          cyc_idx  = 0;
    cyc_t        exp_c;
    logic        exp_taken;
    logic [17:0] act_v, exp_v;

    always @(negedge clk) begin
        if (chk_mode == 1) begin
            case (func3)
                3'b000:  exp_taken = zero;
                3'b001:  exp_taken = !zero;
                3'b100:  exp_taken = lt;
                3'b101:  exp_taken = !lt;
                default: exp_taken = 1'b0;
            endcase
            act_v = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                     alu_src_a, alu_src_b, alu_ctrl, imm_src, illegal};
            exp_v = {exp_c.pcw | (exp_c.brn & exp_taken), exp_c.adr, exp_c.memw, exp_c.irw,
                     exp_c.regw, exp_c.rs, exp_c.a, exp_c.b, exp_c.alu, imm_of(opcode), 1'b0};
            chk($sformatf("cyc_op%b_f3%b_k%0d", opcode, func3, cyc_idx), 32'(act_v), 32'(exp_v));
            if (cyc_idx == 0) chk("fetch_state", 32'(state_dbg), 32'(S_FETCH));
            obs[cyc_idx] = mk(pc_write, adr_src, mem_write, ir_write, reg_write,
                              result_src, alu_src_a, alu_src_b, alu_ctrl, 1'b0);
        end else if (chk_mode == 2) begin
            chk("reset_strobes", {28'd0, pc_write, ir_write, mem_write, reg_write}, 32'd0);
        end
    end

    // Called one step after a rising edge with the DUT in FETCH.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input bit fixed, input logic z, input logic l, input int max_cyc);
        build(op, f3, f75);
        opcode = op; func3 = f3; func7_5 = f75;
        for (int k = 0; k < seq_len && k < max_cyc; k++) begin
            if (fixed) begin zero = z; lt = l; end
            else begin zero = 1'($urandom); lt = 1'($urandom); end
            exp_c = seq[k]; cyc_idx = k; chk_mode = 1;
            @(negedge clk);
            @(posedge clk); #1;
        end
        chk_mode = 0;
    endtask

    // Cycles from FETCH until the DUT is back in FETCH, observed from state_dbg alone.
    task automatic meas_lat(input logic [6:0] op, input logic [2:0] f3, input int lat, input string nm);
        int n = 0;
        opcode = op; func3 = f3; func7_5 = 1'b0;
        zero = 1'($urandom); lt = 1'($urandom);
        do begin
            @(posedge clk); #1;
            n++;
        end while (state_dbg !== 4'(S_FETCH) && n < 12);
        chk(nm, 32'(n), 32'(lat));
    endtask

    function automatic logic [7:0] pattern_regw();
        logic [7:0] p = '0;
        for (int k = 0; k < 8; k++) if (k < seq_len) p[k] = obs[k].regw;
        return p;
    endfunction

    logic [6:0] rand_ops [11];

    initial begin
        rand_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                     7'b1101111, 7'b1100111, 7'b0110111, 7'h7F, 7'h0F, 7'h73};
        rst = 1'b1; opcode = 7'd0; func3 = 3'd0; func7_5 = 1'b0; zero = 1'b0; lt = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", 32'(state_dbg), 32'(S_FETCH));
        chk("rst_strobes", {28'd0, pc_write, ir_write, mem_write, reg_write}, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_instr(7'b0110011, 3'b000, 1'b0, 0, 0, 0, 8);
        chk("add_alu", 32'(obs[2].alu), 32'd0);
        chk("add_regw_only_wb", 32'(pattern_regw()), 32'h08);
        run_instr(7'b0110011, 3'b000, 1'b1, 0, 0, 0, 8);
        chk("sub_alu", 32'(obs[2].alu), 32'd1);
        run_instr(7'b0000011, 3'b010, 1'b0, 0, 0, 0, 8);
        chk("lw_memread_adr", 32'(obs[3].adr), 32'd1);
        chk("lw_memwb", {29'd0, obs[4].rs, obs[4].regw}, {29'd0, 2'b01, 1'b1});
        run_instr(7'b0100011, 3'b010, 1'b0, 0, 0, 0, 8);
        chk("sw_memw", {28'd0, obs[3].memw, obs[2].memw, obs[1].memw, obs[0].memw}, 32'h8);
        run_instr(7'b1100011, 3'b000, 1'b0, 1, 1, 0, 8);
        chk("beq_z1", 32'(obs[2].pcw), 32'd1);
        run_instr(7'b1100011, 3'b001, 1'b0, 1, 1, 0, 8);
        chk("bne_z1", 32'(obs[2].pcw), 32'd0);
        run_instr(7'b1100011, 3'b100, 1'b0, 1, 0, 1, 8);
        chk("blt_l1", 32'(obs[2].pcw), 32'd1);
        run_instr(7'b1100011, 3'b101, 1'b0, 1, 0, 1, 8);
        chk("bge_l1", 32'(obs[2].pcw), 32'd0);
        run_instr(7'b1100011, 3'b010, 1'b0, 1, 1, 1, 8);
        chk("b_f3_010", 32'(obs[2].pcw), 32'd0);
        run_instr(7'b1101111, 3'b000, 1'b0, 0, 0, 0, 8);
        chk("jal_pcw", 32'(obs[2].pcw), 32'd1);
        chk("jal_regw", 32'(obs[3].regw), 32'd1);
        run_instr(7'b1100111, 3'b000, 1'b0, 0, 0, 0, 8);
        chk("jalr_pcw", 32'(obs[2].pcw), 32'd1);
        chk("jalr_regw", 32'(pattern_regw()), 32'h10);

        meas_lat(7'b1100011, 3'b000, 3, "lat_branch");
        meas_lat(7'b0110111, 3'b000, 3, "lat_lui");
        meas_lat(7'b0100011, 3'b010, 4, "lat_sw");
        meas_lat(7'b0110011, 3'b000, 4, "lat_r");
        meas_lat(7'b0010011, 3'b000, 4, "lat_i");
        meas_lat(7'b1101111, 3'b000, 4, "lat_jal");
        meas_lat(7'b0000011, 3'b010, 5, "lat_lw");
        meas_lat(7'b1100111, 3'b000, 5, "lat_jalr");

        // Reset held three cycles while in MEMWRITE.
        run_instr(7'b0100011, 3'b010, 1'b0, 0, 0, 0, 3);
        rst = 1'b1; chk_mode = 2;
        repeat (3) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        chk_mode = 0; rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fetch", 32'(state_dbg), 32'(S_FETCH));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int n = 0; n < 250; n++) begin
`ifdef ILLEGAL_TRAP_EN
            run_instr(rand_ops[$urandom_range(0, 7)], 3'($urandom), 1'($urandom), 0, 0, 0, 8);
`else
            run_instr(rand_ops[$urandom_range(0, 10)], 3'($urandom), 1'($urandom), 0, 0, 0, 8);
`endif
        end

        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0, 0, 8);
`ifdef ILLEGAL_TRAP_EN
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("halt_k%0d", k), {27'd0, illegal, pc_write, ir_write, mem_write, reg_write},
                32'h10);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("halt_exit_illegal", 32'(illegal), 32'd0);
        chk("halt_exit_state", 32'(state_dbg), 32'(S_FETCH));
`else
        @(negedge clk);
        chk("nop_fetch_3rd", 32'(state_dbg), 32'(S_FETCH));
        chk("nop_illegal", 32'(illegal), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
